// File: rtl/pll_lock_rst_seq.sv
// pll_lock_rst_seq
//   Runs on the free-running PLL reference clock. It pulses the PLL reset,
//   waits for a stable lock and then releases the system reset for logic
//   clocked by the PLL outputs. If lock is lost, it re-arms the PLL. After
//   MAX_RETRY lock timeouts it parks in a sticky FAIL state, which only
//   rst_n can clear.
//
// Ports
//   clk         reference clock (PLL input clock domain)
//   rst_n       synchronous active-low reset
//   pll_lock    PLL lock, asynchronous to clk
//   pll_rst     PLL reset, active high
//   sys_rst_n   system reset for PLL-clocked logic, active low
//   locked_ok   high while in RUN
//   pll_fail    high while in FAIL
//   timeout_err 1-cycle pulse per lock timeout
//   lock_lost   1-cycle pulse when lock drops in RUN
//   relock_cnt  saturating count of lock_lost events
//   state_o     current state encoding (debug)
module pll_lock_rst_seq #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 65536,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRY     = 7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_lock,
  output logic       pll_rst,
  output logic       sys_rst_n,
  output logic       locked_ok,
  output logic       pll_fail,
  output logic       timeout_err,
  output logic       lock_lost,
  output logic [7:0] relock_cnt,
  output logic [2:0] state_o
);

  localparam int CNT_MAX0 = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int CNT_MAX  = (CNT_MAX0 > STABLE_CYCLES) ? CNT_MAX0 : STABLE_CYCLES;
  localparam int CW       = $clog2(CNT_MAX);

  localparam logic [CW-1:0] RST_LAST = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] STB_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [7:0]    RETRY_LIM = 8'(MAX_RETRY);

  typedef enum logic [2:0] {
    ST_RST_PLL   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAIL      = 3'd4
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [7:0]    retry, retry_nxt;
  logic [7:0]    relock_nxt;
  logic          to_nxt, ll_nxt;
  logic [1:0]    lock_sync;
  logic          lock_s;

  // 2-FF synchronizer for the asynchronous lock input
  always_ff @(posedge clk) begin
    if (!rst_n) lock_sync <= 2'b00;
    else        lock_sync <= {lock_sync[0], pll_lock};
  end
  assign lock_s = lock_sync[1];

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    retry_nxt  = retry;
    relock_nxt = relock_cnt;
    to_nxt     = 1'b0;
    ll_nxt     = 1'b0;
    case (state)
      ST_RST_PLL: begin
        if (cnt == RST_LAST) begin
          state_nxt = ST_WAIT_LOCK;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      ST_WAIT_LOCK: begin
        // A lock seen on the timeout cycle wins over the timeout
        if (lock_s) begin
          state_nxt = ST_STABLE;
          cnt_nxt   = '0;
        end else if (cnt == TO_LAST) begin
          to_nxt    = 1'b1;
          retry_nxt = retry + 8'd1;
          cnt_nxt   = '0;
          state_nxt = (retry_nxt == RETRY_LIM) ? ST_FAIL : ST_RST_PLL;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      ST_STABLE: begin
        // A glitch restarts the timeout window but is not counted as a retry
        if (!lock_s) begin
          state_nxt = ST_WAIT_LOCK;
          cnt_nxt   = '0;
        end else if (cnt == STB_LAST) begin
          state_nxt = ST_RUN;
          cnt_nxt   = '0;
          retry_nxt = 8'd0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      ST_RUN: begin
        if (!lock_s) begin
          ll_nxt     = 1'b1;
          relock_nxt = (relock_cnt == 8'hFF) ? relock_cnt : relock_cnt + 8'd1;
          state_nxt  = ST_RST_PLL;
          cnt_nxt    = '0;
        end
      end
      ST_FAIL: ;
      default: begin
        state_nxt = ST_RST_PLL;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Level outputs are decoded from the next state, so they are registered
  // and still change on the same edge as state_o.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_RST_PLL;
      cnt         <= '0;
      retry       <= 8'd0;
      relock_cnt  <= 8'd0;
      timeout_err <= 1'b0;
      lock_lost   <= 1'b0;
      pll_rst     <= 1'b1;
      sys_rst_n   <= 1'b0;
      locked_ok   <= 1'b0;
      pll_fail    <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      retry       <= retry_nxt;
      relock_cnt  <= relock_nxt;
      timeout_err <= to_nxt;
      lock_lost   <= ll_nxt;
      pll_rst     <= (state_nxt == ST_RST_PLL) || (state_nxt == ST_FAIL);
      sys_rst_n   <= (state_nxt == ST_RUN);
      locked_ok   <= (state_nxt == ST_RUN);
      pll_fail    <= (state_nxt == ST_FAIL);
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_pll_lock_rst_seq.sv
// tb_pll_lock_rst_seq
//   Directed bench for pll_lock_rst_seq with small parameters
//   (RST_CYCLES=4, LOCK_TIMEOUT=32, STABLE_CYCLES=8, MAX_RETRY=2).
//   Inputs change on negedge; outputs are sampled #1 after posedge.
module tb_pll_lock_rst_seq;

  logic       clk_tb = 1'b0;
  logic       rst_n  = 1'b0;
  logic       pll_lock = 1'b0;
  logic       pll_rst, sys_rst_n, locked_ok, pll_fail, timeout_err, lock_lost;
  logic [7:0] relock_cnt;
  logic [2:0] state_o;

  int n_chk = 0;
  int n_err = 0;
  int n_to  = 0;
  int n_ll  = 0;

  always #5 clk_tb = ~clk_tb;

  pll_lock_rst_seq #(
    .RST_CYCLES(4), .LOCK_TIMEOUT(32), .STABLE_CYCLES(8), .MAX_RETRY(2)
  ) dut (
    .clk(clk_tb), .rst_n(rst_n), .pll_lock(pll_lock),
    .pll_rst(pll_rst), .sys_rst_n(sys_rst_n), .locked_ok(locked_ok),
    .pll_fail(pll_fail), .timeout_err(timeout_err), .lock_lost(lock_lost),
    .relock_cnt(relock_cnt), .state_o(state_o)
  );

  // pulse counters
  always @(negedge clk_tb) begin
    if (timeout_err === 1'b1) n_to++;
    if (lock_lost === 1'b1)   n_ll++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, input string tag);
    int k = 0;
    while (state_o !== s && k < budget) begin
      @(posedge clk_tb); #1; k++;
    end
    chk(tag, 32'(state_o), 32'(s));
  endtask

  // rst_n low for 3 edges; returns on the negedge where rst_n rises
  task automatic do_reset(input logic lk);
    @(negedge clk_tb); rst_n = 1'b0; pll_lock = lk;
    repeat (3) @(posedge clk_tb);
    #1;
    chk("rst_state", 32'(state_o), 0);
    chk("rst_pll_rst", 32'(pll_rst), 1);
    chk("rst_sys_rst_n", 32'(sys_rst_n), 0);
    chk("rst_locked_ok", 32'(locked_ok), 0);
    chk("rst_pll_fail", 32'(pll_fail), 0);
    chk("rst_timeout_err", 32'(timeout_err), 0);
    chk("rst_lock_lost", 32'(lock_lost), 0);
    chk("rst_relock_cnt", 32'(relock_cnt), 0);
    @(negedge clk_tb); rst_n = 1'b1;
  endtask

  // consecutive samples with pll_rst high, starting at the current sample
  task automatic cnt_pll_rst(output int n);
    n = 0;
    while (pll_rst === 1'b1 && n < 50) begin
      n++; @(posedge clk_tb); #1;
    end
  endtask

  // edges from now until sys_rst_n is seen high
  task automatic meas_rel(output int n);
    n = 0;
    do begin
      @(posedge clk_tb); #1; n++;
    end while (sys_rst_n !== 1'b1 && n < 100);
  endtask

  // edges from now until timeout_err is seen high
  task automatic meas_to(output int n);
    n = 0;
    do begin
      @(posedge clk_tb); #1; n++;
    end while (timeout_err !== 1'b1 && n < 100);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, base_to, base_ll, k;

    // 1: nominal lock
    do_reset(1'b0);
    cnt_pll_rst(n);
    chk("nom_pll_rst_len", n, 4);
    repeat (10) @(negedge clk_tb);
    pll_lock = 1'b1;
    @(posedge clk_tb);               // lock first sampled here
    meas_rel(n);
    chk("nom_latency", n, 10);
    chk("nom_locked_ok", 32'(locked_ok), 1);
    chk("nom_state", 32'(state_o), 3);
    chk("nom_relock_cnt", 32'(relock_cnt), 0);

    // 3: lock loss in RUN
    base_ll = n_ll;
    @(negedge clk_tb); pll_lock = 1'b0;
    @(negedge clk_tb); pll_lock = 1'b1;
    k = 0;
    while (pll_rst !== 1'b1 && k < 20) begin
      @(posedge clk_tb); #1; k++;
    end
    chk("loss_lock_lost", 32'(lock_lost), 1);
    chk("loss_relock_cnt", 32'(relock_cnt), 1);
    chk("loss_sys_rst_n", 32'(sys_rst_n), 0);
    chk("loss_locked_ok", 32'(locked_ok), 0);
    cnt_pll_rst(n);
    chk("loss_pll_rst_len", n, 4);
    wait_state(3'd3, 50, "loss_relock");
    chk("loss_pulses", n_ll - base_ll, 1);

    // 2: glitch in STABLE
    do_reset(1'b0);
    base_to = n_to;
    wait_state(3'd1, 20, "gl_wait");
    @(negedge clk_tb); pll_lock = 1'b1;
    repeat (5) @(negedge clk_tb); pll_lock = 1'b0;
    repeat (2) @(negedge clk_tb);
    chk("gl_in_stable", 32'(state_o), 2);
    pll_lock = 1'b1;
    @(posedge clk_tb); #1;           // final rise sampled here
    chk("gl_back_wait", 32'(state_o), 1);
    meas_rel(n);
    chk("gl_latency", n, 10);
    chk("gl_no_timeout", n_to - base_to, 0);

    // 4: timeout and FAIL
    do_reset(1'b0);
    base_to = n_to;
    wait_state(3'd1, 20, "to_wait1");
    meas_to(n);
    chk("to_delay1", n, 32);
    chk("to_state1", 32'(state_o), 0);
    wait_state(3'd1, 20, "to_wait2");
    meas_to(n);
    chk("to_delay2", n, 32);
    chk("to_fail_state", 32'(state_o), 4);
    chk("to_pll_fail", 32'(pll_fail), 1);
    chk("to_pll_rst", 32'(pll_rst), 1);
    @(negedge clk_tb); pll_lock = 1'b1;
    repeat (20) @(posedge clk_tb);
    #1;
    chk("to_sticky", 32'(state_o), 4);
    chk("to_sticky_fail", 32'(pll_fail), 1);
    chk("to_sys_rst_n", 32'(sys_rst_n), 0);
    chk("to_pulses", n_to - base_to, 2);

    // 5: boundary lock on the timeout cycle, on the second attempt
    do_reset(1'b0);
    base_to = n_to;
    wait_state(3'd1, 20, "bnd_wait1");
    meas_to(n);
    chk("bnd_first_to", n, 32);
    wait_state(3'd1, 20, "bnd_wait2");  // entry edge E
    repeat (29) @(posedge clk_tb);
    @(negedge clk_tb); pll_lock = 1'b1;  // sampled at E+30, lock_s at E+31
    repeat (2) @(posedge clk_tb);
    #1;
    chk("bnd_pre", 32'(state_o), 1);
    @(posedge clk_tb); #1;
    chk("bnd_stable", 32'(state_o), 2);
    chk("bnd_no_to_pulse", 32'(timeout_err), 0);
    chk("bnd_to_count", n_to - base_to, 1);
    // retry must still be 1: one more timeout lands in FAIL
    @(negedge clk_tb); pll_lock = 1'b0;
    wait_state(3'd1, 20, "bnd_glitch_wait");
    meas_to(n);
    chk("bnd_second_to", n, 32);
    chk("bnd_fail", 32'(state_o), 4);

    // 6: relock_cnt saturation, then reset in RUN
    do_reset(1'b1);
    base_ll = n_ll;
    wait_state(3'd3, 50, "sat_first_run");
    for (int i = 1; i <= 256; i++) begin
      @(negedge clk_tb); pll_lock = 1'b0;
      @(negedge clk_tb); pll_lock = 1'b1;
      wait_state(3'd0, 20, "sat_drop");
      wait_state(3'd3, 50, "sat_run");
      if (i == 254) chk("sat_254", 32'(relock_cnt), 254);
      if (i == 255) chk("sat_255", 32'(relock_cnt), 255);
    end
    chk("sat_256", 32'(relock_cnt), 255);
    chk("sat_pulses", n_ll - base_ll, 256);
    @(negedge clk_tb); rst_n = 1'b0;
    @(posedge clk_tb); #1;
    chk("mid_sys_rst_n", 32'(sys_rst_n), 0);
    chk("mid_relock_cnt", 32'(relock_cnt), 0);
    chk("mid_state", 32'(state_o), 0);
    chk("mid_pll_rst", 32'(pll_rst), 1);
    @(negedge clk_tb); rst_n = 1'b1;

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
